// File: rtl/reg_operand_scoreboard_pkg.sv
// rtl/reg_operand_scoreboard_pkg.sv - shared forwarding encodings and scoreboard entry type
//
// Used by the scoreboard, the ID stage and the EX operand muxes.
//   FWD_*      : operand source select encoding
//   REG_ZERO   : hardwired-zero register number
//   sb_entry_t : one in-flight position {valid, rd, load}
//   pos_to_fwd : maps a pipeline position (0=EX,1=MEM,2=WB,3=past WB) to a select
package reg_operand_scoreboard_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       load;
  } sb_entry_t;

  // Position 3 only exists with four tracked stages; by then the register
  // file already holds the value, so it reads from the regfile.
  function automatic logic [1:0] pos_to_fwd(input logic [1:0] pos);
    case (pos)
      2'd0:    return FWD_EX;
      2'd1:    return FWD_MEM;
      2'd2:    return FWD_WB;
      default: return FWD_RF;
    endcase
  endfunction

endpackage

// File: rtl/reg_operand_scoreboard_sb_src_match.sv
// rtl/reg_operand_scoreboard_sb_src_match.sv - youngest in-flight match for one source operand
//
// Ports:
//   entries      in  STAGES scoreboard entries, index 0 = youngest (EX)
//   src          in  source register number
//   use_src      in  source is actually read by the instruction
//   hit          out some valid entry targets src
//   idx          out position of the youngest matching entry
//   load_at_pos0 out youngest match is a load still in EX (load-use hazard)
module sb_src_match
  import reg_operand_scoreboard_pkg::*;
#(
  parameter int STAGES = 3
) (
  input  sb_entry_t [STAGES-1:0] entries,
  input  logic [4:0]             src,
  input  logic                   use_src,
  output logic                   hit,
  output logic [1:0]             idx,
  output logic                   load_at_pos0
);

  // Scan oldest to youngest so the lowest index overwrites and wins.
  always_comb begin
    hit = 1'b0;
    idx = 2'd0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (use_src && (src != REG_ZERO) && entries[i].valid && (entries[i].rd == src)) begin
        hit = 1'b1;
        idx = 2'(i);
      end
    end
    load_at_pos0 = hit && (idx == 2'd0) && entries[0].load;
  end

endmodule

// File: rtl/reg_operand_scoreboard.sv
// rtl/reg_operand_scoreboard.sv - in-flight destination tracking, issue stall and operand forwarding
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   issue_valid               ID holds an instruction
//   issue_rs / issue_rt       source A / B register numbers
//   issue_use_rs / _use_rt    source A / B actually read
//   issue_wen / issue_rd      instruction writes issue_rd
//   issue_load                instruction is a load (result from MEM onward)
//   flush                     kill the instruction in EX and the one in ID
//   issue_ready               ID may advance this cycle
//   fwd_a / fwd_b             operand source: 0=regfile 1=EX 2=MEM 3=WB
//   pend_mask                 bit r set when a valid in-flight entry targets r
//   stall_cnt / flush_cnt     (SCOREBOARD_PERF_EN only) stall and flush cycle counters
module reg_operand_scoreboard
  import reg_operand_scoreboard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int NREG   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rs,
  input  logic [4:0]      issue_rt,
  input  logic            issue_use_rs,
  input  logic            issue_use_rt,
  input  logic            issue_wen,
  input  logic [4:0]      issue_rd,
  input  logic            issue_load,
  input  logic            flush,
  output logic            issue_ready,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic [NREG-1:0] pend_mask
`ifdef SCOREBOARD_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  sb_entry_t [STAGES-1:0] ent;
  sb_entry_t              new_ent;

  logic       hit_a, hit_b;
  logic [1:0] idx_a, idx_b;
  logic       ld_a, ld_b;
  logic       stall;

  sb_src_match #(.STAGES(STAGES)) u_match_a (
    .entries      (ent),
    .src          (issue_rs),
    .use_src      (issue_use_rs),
    .hit          (hit_a),
    .idx          (idx_a),
    .load_at_pos0 (ld_a)
  );

  sb_src_match #(.STAGES(STAGES)) u_match_b (
    .entries      (ent),
    .src          (issue_rt),
    .use_src      (issue_use_rt),
    .hit          (hit_b),
    .idx          (idx_b),
    .load_at_pos0 (ld_b)
  );

  // Only a load sitting in EX can stall: one cycle later it reaches MEM and forwards.
  assign stall       = issue_valid & (ld_a | ld_b);
  assign issue_ready = ~stall & ~flush;

  assign fwd_a = hit_a ? pos_to_fwd(idx_a) : FWD_RF;
  assign fwd_b = hit_b ? pos_to_fwd(idx_b) : FWD_RF;

  always_comb begin
    pend_mask = '0;
    for (int r = 0; r < NREG; r++) begin
      for (int i = 0; i < STAGES; i++) begin
        if (ent[i].valid && (ent[i].rd == r[4:0])) pend_mask[r] = 1'b1;
      end
    end
  end

  // r0 writes never occupy an entry, so they can never be forwarded.
  always_comb begin
    new_ent.valid = issue_valid & issue_ready & issue_wen & (issue_rd != REG_ZERO);
    new_ent.rd    = issue_rd;
    new_ent.load  = issue_load;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent <= '0;
    end else begin
      ent[0] <= new_ent;
      // A flush kills the EX instruction as it would move to MEM.
      ent[1] <= flush ? sb_entry_t'('0) : ent[0];
      for (int i = 2; i < STAGES; i++) ent[i] <= ent[i-1];
    end
  end

`ifdef SCOREBOARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall & ~flush) stall_cnt <= stall_cnt + 32'd1;
      if (flush)          flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_operand_scoreboard.sv
// tb/tb_reg_operand_scoreboard.sv - scoreboard-style bench for reg_operand_scoreboard
module tb_reg_operand_scoreboard;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs = '0;
  logic [4:0]  issue_rt = '0;
  logic        issue_use_rs = 1'b0;
  logic        issue_use_rt = 1'b0;
  logic        issue_wen = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_load = 1'b0;
  logic        flush = 1'b0;
  logic        issue_ready;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] pend_mask;
`ifdef SCOREBOARD_PERF_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic        rdy;
    logic [1:0]  a;
    logic [1:0]  b;
    logic [31:0] pm;
  } exp_t;

  exp_t exp_q[$];

  reg_operand_scoreboard #(.STAGES(3), .NREG(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_rs     (issue_rs),
    .issue_rt     (issue_rt),
    .issue_use_rs (issue_use_rs),
    .issue_use_rt (issue_use_rt),
    .issue_wen    (issue_wen),
    .issue_rd     (issue_rd),
    .issue_load   (issue_load),
    .flush        (flush),
    .issue_ready  (issue_ready),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .pend_mask    (pend_mask)
`ifdef SCOREBOARD_PERF_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are combinational, so every cycle presents a response;
  // sample it on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.name, ".ready"}, 32'(issue_ready), 32'(e.rdy));
      chk({e.name, ".fwd_a"}, 32'(fwd_a), 32'(e.a));
      chk({e.name, ".fwd_b"}, 32'(fwd_b), 32'(e.b));
      chk({e.name, ".pend"},  pend_mask, e.pm);
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the
  // hand-computed response for that cycle.
  task automatic step(input string name, input logic r, input logic v,
                      input logic [4:0] rs, input logic urs,
                      input logic [4:0] rt, input logic urt,
                      input logic wen, input logic [4:0] rd, input logic ld, input logic fl,
                      input logic rdy, input logic [1:0] a, input logic [1:0] b,
                      input logic [31:0] pm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; issue_valid = v;
    issue_rs = rs; issue_use_rs = urs;
    issue_rt = rt; issue_use_rt = urt;
    issue_wen = wen; issue_rd = rd; issue_load = ld; flush = fl;
    e.name = name; e.rdy = rdy; e.a = a; e.b = b; e.pm = pm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      issue_valid = 0; issue_rs = 0; issue_rt = 0; issue_use_rs = 0; issue_use_rt = 0;
      issue_wen = 0; issue_rd = 0; issue_load = 0; flush = 0;
    end
  endtask

  initial begin
    //    name    rst v  rs urs rt urt wen rd ld fl   rdy a  b  pend
    step("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0);
    // add rd=5 followed by readers: EX, MEM, WB, then regfile
    step("fw_c1", 0, 1, 1, 1, 2, 1, 1, 5, 0, 0,   1, 0, 0, 32'h0);
    step("fw_ex", 0, 1, 5, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 32'h20);
    step("fw_mem",0, 1, 5, 1, 5, 1, 0, 0, 0, 0,   1, 2, 2, 32'h20);
    step("fw_wb", 0, 1, 5, 1, 5, 0, 0, 0, 0, 0,   1, 3, 0, 32'h20);
    step("fw_rf", 0, 1, 5, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0);
    // lw rd=8 then add rs=8: one bubble, then MEM forward
    step("ld_lw", 0, 1, 0, 0, 0, 0, 1, 8, 1, 0,   1, 0, 0, 32'h0);
    step("ld_stl",0, 1, 8, 1, 0, 0, 1, 10,0, 0,   0, 1, 0, 32'h100);
    step("ld_go", 0, 1, 8, 1, 0, 0, 1, 10,0, 0,   1, 2, 0, 32'h100);
    step("ld_pm", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h500);
    idle(3);
    // back-to-back writes to r3: youngest wins
    step("yg_add",0, 1, 0, 0, 0, 0, 1, 3, 0, 0,   1, 0, 0, 32'h0);
    step("yg_sub",0, 1, 0, 0, 0, 0, 1, 3, 0, 0,   1, 0, 0, 32'h8);
    step("yg_use",0, 1, 3, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 32'h8);
    idle(3);
    // writes to r0 are never tracked
    step("z_wr",  0, 1, 0, 0, 0, 0, 1, 0, 0, 0,   1, 0, 0, 32'h0);
    step("z_rd",  0, 1, 0, 1, 0, 1, 0, 0, 0, 0,   1, 0, 0, 32'h0);
    idle(3);
    // flush kills the EX add rd=9 and blocks ID
    step("fl_add",0, 1, 0, 0, 0, 0, 1, 9, 0, 0,   1, 0, 0, 32'h0);
    step("fl_fl", 0, 1, 9, 1, 0, 0, 1, 11,0, 1,   0, 1, 0, 32'h200);
    step("fl_aft",0, 1, 9, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0);
    // flush together with a load-use stall on B
    step("fs_lw", 0, 1, 0, 0, 0, 0, 1, 8, 1, 0,   1, 0, 0, 32'h0);
    step("fs_fl", 0, 1, 0, 0, 8, 1, 0, 0, 0, 1,   0, 0, 1, 32'h100);
    step("fs_aft",0, 1, 0, 0, 8, 1, 0, 0, 0, 0,   1, 0, 0, 32'h0);
    // fill three entries, then reset mid-stream
    step("rs_1",  0, 1, 0, 0, 0, 0, 1, 1, 0, 0,   1, 0, 0, 32'h0);
`ifdef SCOREBOARD_PERF_EN
    chk("stall_cnt", stall_cnt, 32'd1);
    chk("flush_cnt", flush_cnt, 32'd2);
`endif
    step("rs_2",  0, 1, 0, 0, 0, 0, 1, 2, 0, 0,   1, 0, 0, 32'h2);
    step("rs_4",  0, 1, 0, 0, 0, 0, 1, 4, 0, 0,   1, 0, 0, 32'h6);
    step("rs_6",  0, 1, 1, 1, 0, 0, 1, 6, 0, 0,   1, 3, 0, 32'h16);
    step("rs_on", 1, 1, 4, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0);
    step("rs_off",0, 1, 4, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 32'h0);
`ifdef SCOREBOARD_PERF_EN
    chk("cnt_rst", flush_cnt | stall_cnt, 32'd0);
`endif
    idle(1);
    begin
      int guard = 0;
      while (exp_q.size() > 0 && guard < 10) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (exp_q.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d responses never checked, expected 0", exp_q.size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
